// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO ownership and pipeline stall generation.
// Optional macro MDU_FAST_MULT_EN: single-cycle combinational multiply for MULT/MULTU.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_hilo,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               is_div_q;
    logic               neg_q_q;
    logic               neg_r_q;
    logic               dz_q;
    logic               done_q;

    logic               is_arith, is_mthi, is_mtlo, is_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_part, div_diff;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic [WIDTH-1:0]   quot, rem;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // flush masks every new request, including MTHI/MTLO
    assign is_arith  = start & ~flush & ~op[2];
    assign is_mthi   = start & ~flush & (op == 3'b100);
    assign is_mtlo   = start & ~flush & (op == 3'b101);
    assign is_signed = ~op[0];
    assign mag_a     = (is_signed & a[WIDTH-1]) ? -a : a;
    assign mag_b     = (is_signed & b[WIDTH-1]) ? -b : b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (is_arith) begin
`ifdef MDU_FAST_MULT_EN
                    state_d = op[1] ? RUN : FIN;
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != IDLE);
        stall = busy & (start | rd_hilo);
        hi    = hi_q;
        lo    = lo_q;
        done  = done_q;
    end

    // One iteration: acc holds {partial product, multiplier} or {remainder, quotient}
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
        div_part = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff = div_part - {1'b0, opnd_q};
        if (is_div_q) begin
            if (div_diff[WIDTH]) begin
                acc_d = {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_comb begin
`ifdef MDU_FAST_MULT_EN
        prod_mag = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
`else
        prod_mag = acc_q;
`endif
        prod = neg_q_q ? -prod_mag : prod_mag;
        quot = acc_q[WIDTH-1:0];
        rem  = acc_q[2*WIDTH-1:WIDTH];
        if (!is_div_q) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (dz_q) begin
            res_hi = a_raw_q;
            res_lo = {WIDTH{1'b1}};
        end else begin
            res_hi = neg_r_q ? -rem : rem;
            res_lo = neg_q_q ? -quot : quot;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_raw_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (is_arith) begin
                        opnd_q   <= op[1] ? mag_b : mag_a;
                        acc_q    <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                        is_div_q <= op[1];
                        neg_q_q  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r_q  <= is_signed & a[WIDTH-1];
                        dz_q     <= op[1] & (b == '0);
                        a_raw_q  <= a;
                        cnt_q    <= '0;
                    end else if (is_mthi) begin
                        hi_q <= a;
                    end else if (is_mtlo) begin
                        lo_q <= a;
                    end
                end
                RUN: begin
                    if (!flush) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                FIN: begin
                    if (!flush) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter: vector table plus stall, flush and reset sequences.
module tb_mdu_iter;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        rd_hilo;
    logic        flush;
    logic [31:0] hi, lo;
    logic        busy, stall, done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    vec_t vecs[10];

    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .rd_hilo(rd_hilo), .flush(flush), .hi(hi), .lo(lo),
        .busy(busy), .stall(stall), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int expBusy(input logic [2:0] o);
`ifdef MDU_FAST_MULT_EN
        return o[1] ? 33 : 1;
`else
        return 33;
`endif
    endfunction

    // Issue one op, then count busy cycles and done pulses until the unit is idle again
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                                 output int busyCycles, output int donePulses);
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        @(negedge clk);
        start = 1'b0;
        busyCycles = 0;
        donePulses = 0;
        while (busy && busyCycles < 100) begin
            busyCycles++;
            if (done) donePulses++;
            @(negedge clk);
        end
        if (done) donePulses++;
        @(negedge clk);
        if (done) donePulses++;
    endtask

    initial begin
        int cyc, pulses, stallBad, doneSeen;

        vecs[0] = '{OP_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[6] = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[7] = '{OP_MULT,  32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000};
        vecs[8] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        reset = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
        rd_hilo = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_hi", {32'h0, hi}, 64'h0);
        checkOutput("reset_lo", {32'h0, lo}, 64'h0);
        checkOutput("reset_busy", {63'h0, busy}, 64'h0);
        checkOutput("reset_done", {63'h0, done}, 64'h0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, cyc, pulses);
            checkOutput($sformatf("vec%0d_hi", i), {32'h0, hi}, {32'h0, vecs[i].expHi});
            checkOutput($sformatf("vec%0d_lo", i), {32'h0, lo}, {32'h0, vecs[i].expLo});
            checkOutput($sformatf("vec%0d_busy_cycles", i), 64'(cyc), 64'(expBusy(vecs[i].op)));
            checkOutput($sformatf("vec%0d_done_pulses", i), 64'(pulses), 64'd1);
        end

        // MTHI/MTLO write in one edge without raising busy or done
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; a = 32'h1234;
        @(negedge clk);
        checkOutput("mthi_hi", {32'h0, hi}, 64'h1234);
        checkOutput("mthi_busy", {63'h0, busy}, 64'h0);
        op = OP_MTLO; a = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        checkOutput("mtlo_lo", {32'h0, lo}, 64'h5678);
        checkOutput("mtlo_hi_kept", {32'h0, hi}, 64'h1234);
        checkOutput("mtlo_busy", {63'h0, busy}, 64'h0);
        checkOutput("mtlo_done", {63'h0, done}, 64'h0);

        // rd_hilo during DIVU: stall every busy cycle, no stall once idle
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0; rd_hilo = 1'b1;
        cyc = 0; stallBad = 0;
        while (busy && cyc < 100) begin
            cyc++;
            if (stall !== 1'b1 || hi !== 32'h1234 || lo !== 32'h5678) stallBad++;
            @(negedge clk);
        end
        checkOutput("rdhilo_busy_cycles", 64'(cyc), 64'd33);
        checkOutput("rdhilo_stall_hold", 64'(stallBad), 64'd0);
        checkOutput("rdhilo_idle_stall", {63'h0, stall}, 64'h0);
        checkOutput("rdhilo_new_hi", {32'h0, hi}, 64'h2);
        checkOutput("rdhilo_new_lo", {32'h0, lo}, 64'hE);
        rd_hilo = 1'b0;

        // Back-to-back start: second op held by stall, launches in first idle cycle
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd10;
        @(negedge clk);
        op = OP_MULTU; a = 32'd3; b = 32'd5;
        cyc = 0; stallBad = 0;
        while (busy && cyc < 100) begin
            cyc++;
            if (stall !== 1'b1) stallBad++;
            @(negedge clk);
        end
        checkOutput("b2b_stall", 64'(stallBad), 64'd0);
        checkOutput("b2b_idle_stall", {63'h0, stall}, 64'h0);
        checkOutput("b2b_first_hi", {32'h0, hi}, 64'h0);
        checkOutput("b2b_first_lo", {32'h0, lo}, 64'h64);
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_second_busy", {63'h0, busy}, 64'h1);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        checkOutput("b2b_second_cycles", 64'(cyc), 64'(expBusy(OP_MULTU)));
        checkOutput("b2b_second_lo", {32'h0, lo}, 64'hF);
        checkOutput("b2b_second_hi", {32'h0, hi}, 64'h0);

        // Flush at iteration 10: result dropped, hi/lo held, done never pulses
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("flush_pre_busy", {63'h0, busy}, 64'h1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_busy", {63'h0, busy}, 64'h0);
        checkOutput("flush_hi", {32'h0, hi}, 64'h0);
        checkOutput("flush_lo", {32'h0, lo}, 64'hF);
        doneSeen = 0;
        repeat (40) begin
            if (done) doneSeen++;
            @(negedge clk);
        end
        checkOutput("flush_no_done", 64'(doneSeen), 64'd0);

        // flush with start in IDLE: request ignored
        start = 1'b1; flush = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd2;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checkOutput("flush_idle_busy", {63'h0, busy}, 64'h0);
        checkOutput("flush_idle_lo", {32'h0, lo}, 64'hF);

        // Async reset mid-operation clears state immediately
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("areset_busy", {63'h0, busy}, 64'h0);
        checkOutput("areset_hi", {32'h0, hi}, 64'h0);
        checkOutput("areset_lo", {32'h0, lo}, 64'h0);
        @(negedge clk);
        reset = 1'b1;

        // Recovery after reset
        applyStimulus(OP_DIVU, 32'd1000, 32'd3, cyc, pulses);
        checkOutput("post_reset_lo", {32'h0, lo}, 64'd333);
        checkOutput("post_reset_hi", {32'h0, hi}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
